// File: rtl/shift_right_seq.sv
// Multi-cycle 32-bit right shifter: N+1 cycles Start->Done (ceil(N/2)+1 with SHIFT_RIGHT_SEQ_STEP2_EN).
// Start is ignored while Busy; Out32 holds its result until the next accepted Start.
module shift_right_seq (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Start,
  input  logic [31:0] In32,
  input  logic [4:0]  Shamt,
  input  logic        Arith,
  output logic [31:0] Out32,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] out_q, out_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        fill_q, fill_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      out_q   <= 32'h0000_0000;
      cnt_q   <= 5'd0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          out_d   = In32;
          cnt_d   = Shamt;
          fill_d  = Arith & In32[31];
          state_d = (Shamt == 5'd0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
`ifdef SHIFT_RIGHT_SEQ_STEP2_EN
        // Two positions per cycle; a trailing odd bit takes one single step.
        if (cnt_q >= 5'd2) begin
          out_d = {fill_q, fill_q, out_q[31:2]};
          cnt_d = cnt_q - 5'd2;
        end else begin
          out_d = {fill_q, out_q[31:1]};
          cnt_d = cnt_q - 5'd1;
        end
`else
        out_d = {fill_q, out_q[31:1]};
        cnt_d = cnt_q - 5'd1;
`endif
        if (cnt_d == 5'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign Out32 = out_q;
  assign Busy  = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign Done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: hand-computed results and Start->Done latencies.
module tb_shift_right_seq;

  logic        Clk;
  logic        Rst_n;
  logic        Start;
  logic [31:0] In32;
  logic [4:0]  Shamt;
  logic        Arith;
  logic [31:0] Out32;
  logic        Busy;
  logic        Done;

  int n_total;
  int n_bad;

  shift_right_seq dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .In32  (In32),
    .Shamt (Shamt),
    .Arith (Arith),
    .Out32 (Out32),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input int n);
`ifdef SHIFT_RIGHT_SEQ_STEP2_EN
    return (n + 1) / 2 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Launch one operation; lat counts negedges after the accept edge until Done.
  task automatic run_op(input logic [31:0] din, input logic [4:0] sh, input logic ar,
                        input logic disturb, output logic [31:0] res, output int lat);
    @(negedge Clk);
    In32 = din; Shamt = sh; Arith = ar; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0; In32 = 32'h0; Shamt = 5'd0; Arith = 1'b0;
    lat = 0;
    res = 32'hx;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clk);
      lat++;
      if (Done) begin
        res = Out32;
        break;
      end
      if (disturb && lat == 2) begin
        In32 = 32'h1234_5678; Shamt = 5'd1; Arith = 1'b0; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    Start = 1'b0;
  endtask

  logic [31:0] res;
  int          lat;

  initial begin
    n_total = 0;
    n_bad   = 0;
    Rst_n = 1'b0; Start = 1'b0; In32 = 32'h0; Shamt = 5'd0; Arith = 1'b0;
    #12;
    chk("rst_out",  Out32, 32'h0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Reset asserted in the middle of a long shift.
    @(negedge Clk);
    In32 = 32'h8000_0000; Shamt = 5'd20; Arith = 1'b1; Start = 1'b1;
    @(posedge Clk);
    #1 Start = 1'b0;
    repeat (5) @(negedge Clk);
    chk("mid_busy", {31'd0, Busy}, 32'd1);
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_out",  Out32, 32'h0);
    chk("mid_rst_busy", {31'd0, Busy}, 32'd0);
    chk("mid_rst_done", {31'd0, Done}, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    run_op(32'h8000_0000, 5'd4, 1'b0, 1'b0, res, lat);
    chk("lsr4_res", res, 32'h0800_0000);
    chk("lsr4_lat", lat, exp_lat(4));
    @(negedge Clk);
    chk("hold_out",  Out32, 32'h0800_0000);
    chk("hold_busy", {31'd0, Busy}, 32'd0);

    run_op(32'h8000_0000, 5'd4, 1'b1, 1'b0, res, lat);
    chk("asr4_res", res, 32'hF800_0000);
    chk("asr4_lat", lat, exp_lat(4));

    run_op(32'h7FFF_FFF0, 5'd4, 1'b1, 1'b0, res, lat);
    chk("asr4_pos_res", res, 32'h07FF_FFFF);

    run_op(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, res, lat);
    chk("sh0_res", res, 32'hDEAD_BEEF);
    chk("sh0_lat", lat, 1);

    run_op(32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, res, lat);
    chk("lsr31_res", res, 32'h0000_0001);
    chk("lsr31_lat", lat, exp_lat(31));

    run_op(32'hFFFF_FFFF, 5'd31, 1'b1, 1'b0, res, lat);
    chk("asr31_res", res, 32'hFFFF_FFFF);
    chk("asr31_lat", lat, exp_lat(31));

    run_op(32'h0000_0F00, 5'd5, 1'b0, 1'b0, res, lat);
    chk("lsr5_odd_res", res, 32'h0000_0078);
    chk("lsr5_odd_lat", lat, exp_lat(5));

    // Inputs and Start changed while busy must not disturb the operation.
    run_op(32'h8000_0000, 5'd4, 1'b1, 1'b1, res, lat);
    chk("busy_prot_res", res, 32'hF800_0000);
    chk("busy_prot_lat", lat, exp_lat(4));
    @(negedge Clk);
    chk("busy_prot_idle", {31'd0, Busy}, 32'd0);

    // Start held high: accepts only from IDLE, Done exactly one cycle wide.
    @(negedge Clk);
    In32 = 32'h0000_00F0; Shamt = 5'd2; Arith = 1'b0; Start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int waited;
      waited = 0;
      while (!Done && waited < 100) begin
        @(negedge Clk);
        waited++;
      end
      chk("b2b_done_seen", {31'd0, Done}, 32'd1);
      chk("b2b_res", Out32, 32'h0000_003C);
      @(negedge Clk);
      chk("b2b_done_width", {31'd0, Done}, 32'd0);
      chk("b2b_idle_gap",   {31'd0, Busy}, 32'd0);
      @(negedge Clk);
      chk("b2b_reaccept",   {31'd0, Busy}, 32'd1);
    end
    Start = 1'b0;
    repeat (6) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
